// File: rtl/control_sequencer.sv
// SAP control sequencer: T1..T6 ring counter plus HALT.
// State moves on the falling edge; control word is Moore-decoded.
module control_sequencer #(
    parameter logic [3:0] OP_LDA    = 4'h0,
    parameter logic [3:0] OP_ADD    = 4'h1,
    parameter logic [3:0] OP_SUB    = 4'h2,
    parameter logic [3:0] OP_OUT    = 4'hE,
    parameter logic [3:0] OP_HLT    = 4'hF,
    parameter int         CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           opcode,
    output logic                 cp,
    output logic                 ep,
    output logic                 lm_n,
    output logic                 ce_n,
    output logic                 l1_n,
    output logic                 e1_n,
    output logic                 la_n,
    output logic                 ea,
    output logic                 su,
    output logic                 eu,
    output logic                 lb_n,
    output logic                 lo_n,
    output logic [5:0]           t_state,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count
);

    // One-hot ring; bits [5:0] map straight onto t_state.
    typedef enum logic [6:0] {
        S_T1   = 7'b0000001,
        S_T2   = 7'b0000010,
        S_T3   = 7'b0000100,
        S_T4   = 7'b0001000,
        S_T5   = 7'b0010000,
        S_T6   = 7'b0100000,
        S_HALT = 7'b1000000
    } state_t;

    state_t state;
    state_t state_nxt;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;

    // Opcode class decode, only consumed in T4..T6.
    always_comb begin
        is_lda = (opcode == OP_LDA);
        is_add = (opcode == OP_ADD);
        is_sub = (opcode == OP_SUB);
        is_out = (opcode == OP_OUT);
        is_hlt = (opcode == OP_HLT);
    end

    // Ring position register; reset and illegal codes land in T1.
    always_ff @(negedge clk) begin
        if (!rst) begin
            state <= S_T1;
        end else begin
            state <= state_nxt;
        end
    end

    // Retired-instruction counter, bumps on the T6->T1 wrap.
    always_ff @(negedge clk) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (state == S_T6) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    // Next-state and control-word decode; reset forces all inactive.
    always_comb begin
        state_nxt = S_T1;
        cp        = 1'b0;
        ep        = 1'b0;
        lm_n      = 1'b1;
        ce_n      = 1'b1;
        l1_n      = 1'b1;
        e1_n      = 1'b1;
        la_n      = 1'b1;
        ea        = 1'b0;
        su        = 1'b0;
        eu        = 1'b0;
        lb_n      = 1'b1;
        lo_n      = 1'b1;
        halted    = 1'b0;
        case (state)
            S_T1: begin
                state_nxt = S_T2;
                if (rst) begin
                    ep   = 1'b1;
                    lm_n = 1'b0;
                end
            end
            S_T2: begin
                state_nxt = S_T3;
                if (rst) begin
                    cp = 1'b1;
                end
            end
            S_T3: begin
                state_nxt = S_T4;
                if (rst) begin
                    ce_n = 1'b0;
                    l1_n = 1'b0;
                end
            end
            S_T4: begin
                state_nxt = is_hlt ? S_HALT : S_T5;
                if (rst) begin
                    if (is_lda || is_add || is_sub) begin
                        e1_n = 1'b0;
                        lm_n = 1'b0;
                    end else if (is_out) begin
                        ea   = 1'b1;
                        lo_n = 1'b0;
                    end
                end
            end
            S_T5: begin
                state_nxt = S_T6;
                if (rst) begin
                    if (is_lda) begin
                        ce_n = 1'b0;
                        la_n = 1'b0;
                    end else if (is_add || is_sub) begin
                        ce_n = 1'b0;
                        lb_n = 1'b0;
                    end
                end
            end
            S_T6: begin
                state_nxt = S_T1;
                if (rst && (is_add || is_sub)) begin
                    eu   = 1'b1;
                    su   = is_sub;
                    la_n = 1'b0;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
                halted    = rst;
            end
            default: begin
                state_nxt = S_T1;
            end
        endcase
    end

    // Ring position view; zero in HALT and for any illegal code.
    always_comb begin
        t_state = 6'b000000;
        case (state)
            S_T1, S_T2, S_T3,
            S_T4, S_T5, S_T6: t_state = state[5:0];
            default:          t_state = 6'b000000;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer.
// Stimulus pushes expected control words; a monitor checks on posedge.
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       cp, ep, lm_n, ce_n, l1_n, e1_n;
    logic       la_n, ea, su, eu, lb_n, lo_n;
    logic [5:0] t_state;
    logic       halted;
    logic [7:0] instr_count;

    control_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .cp          (cp),
        .ep          (ep),
        .lm_n        (lm_n),
        .ce_n        (ce_n),
        .l1_n        (l1_n),
        .e1_n        (e1_n),
        .la_n        (la_n),
        .ea          (ea),
        .su          (su),
        .eu          (eu),
        .lb_n        (lb_n),
        .lo_n        (lo_n),
        .t_state     (t_state),
        .halted      (halted),
        .instr_count (instr_count)
    );

    // Control word packing {cp,ep,lm_n,ce_n,l1_n,e1_n,la_n,ea,su,eu,lb_n,lo_n}
    localparam logic [11:0] IDLE = 12'h3E3;
    localparam logic [11:0] CP = 12'h800;
    localparam logic [11:0] EP = 12'h400;
    localparam logic [11:0] LM = 12'h200;
    localparam logic [11:0] CE = 12'h100;
    localparam logic [11:0] L1 = 12'h080;
    localparam logic [11:0] E1 = 12'h040;
    localparam logic [11:0] LA = 12'h020;
    localparam logic [11:0] EA = 12'h010;
    localparam logic [11:0] SU = 12'h008;
    localparam logic [11:0] EU = 12'h004;
    localparam logic [11:0] LB = 12'h002;
    localparam logic [11:0] LO = 12'h001;

    typedef struct {
        string       tag;
        logic [11:0] cw;
        logic [5:0]  ts;
        logic        h;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       q[$];
    int         n_checks;
    int         n_fails;
    logic [7:0] ecnt;
    logic [11:0] act_cw;

    assign act_cw = {cp, ep, lm_n, ce_n, l1_n, e1_n,
                     la_n, ea, su, eu, lb_n, lo_n};

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, %0d entries pending", q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: outputs are stable mid-cycle, sample on rising edge.
    always @(posedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (act_cw !== e.cw || t_state !== e.ts ||
                halted !== e.h || instr_count !== e.cnt) begin
                n_fails++;
                $display("FAIL %s: got cw=%h ts=%b h=%b cnt=%h, want cw=%h ts=%b h=%b cnt=%h",
                         e.tag, act_cw, t_state, halted, instr_count,
                         e.cw, e.ts, e.h, e.cnt);
            end
        end
    end

    // One cycle: set inputs after the falling edge, queue expectation.
    task automatic step(input logic r, input logic [3:0] op,
                        input logic [11:0] cw, input logic [5:0] ts,
                        input logic h, input string tag);
        exp_t e;
        @(negedge clk);
        #1;
        rst    = r;
        opcode = op;
        e.tag  = tag;
        e.cw   = cw;
        e.ts   = ts;
        e.h    = h;
        e.cnt  = ecnt;
        q.push_back(e);
    endtask

    // Full instruction; op_early is driven during fetch and must be ignored.
    task automatic instr(input logic [3:0] op_early, input logic [3:0] op,
                         input logic [11:0] w4, input logic [11:0] w5,
                         input logic [11:0] w6, input string tag);
        step(1'b1, op_early, IDLE ^ EP ^ LM, 6'b000001, 1'b0, {tag, "_T1"});
        step(1'b1, op_early, IDLE ^ CP,      6'b000010, 1'b0, {tag, "_T2"});
        step(1'b1, op_early, IDLE ^ CE ^ L1, 6'b000100, 1'b0, {tag, "_T3"});
        step(1'b1, op, w4, 6'b001000, 1'b0, {tag, "_T4"});
        step(1'b1, op, w5, 6'b010000, 1'b0, {tag, "_T5"});
        step(1'b1, op, w6, 6'b100000, 1'b0, {tag, "_T6"});
        ecnt = ecnt + 8'd1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        ecnt     = 8'h00;
        rst      = 1'b0;
        opcode   = 4'h1;

        // Reset held for two falling edges, outputs forced idle.
        step(1'b0, 4'h1, IDLE, 6'b000001, 1'b0, "rst0");
        step(1'b0, 4'h1, IDLE, 6'b000001, 1'b0, "rst1");

        instr(4'h0, 4'h0, IDLE ^ E1 ^ LM, IDLE ^ CE ^ LA, IDLE, "lda");
        instr(4'h2, 4'h2, IDLE ^ E1 ^ LM, IDLE ^ CE ^ LB,
              IDLE ^ EU ^ SU ^ LA, "sub");
        instr(4'h1, 4'h1, IDLE ^ E1 ^ LM, IDLE ^ CE ^ LB,
              IDLE ^ EU ^ LA, "add");
        instr(4'hE, 4'hE, IDLE ^ EA ^ LO, IDLE, IDLE, "out");
        instr(4'h7, 4'h7, IDLE, IDLE, IDLE, "nop");
        // Fetch-time opcode is HLT, decode-time is ADD: must act as ADD.
        instr(4'hF, 4'h1, IDLE ^ E1 ^ LM, IDLE ^ CE ^ LB,
              IDLE ^ EU ^ LA, "late_add");

        // HLT: T1..T4 then absorbing HALT with frozen count.
        step(1'b1, 4'hF, IDLE ^ EP ^ LM, 6'b000001, 1'b0, "hlt_T1");
        step(1'b1, 4'hF, IDLE ^ CP,      6'b000010, 1'b0, "hlt_T2");
        step(1'b1, 4'hF, IDLE ^ CE ^ L1, 6'b000100, 1'b0, "hlt_T3");
        step(1'b1, 4'hF, IDLE,           6'b001000, 1'b0, "hlt_T4");
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'(i), IDLE, 6'b000000, 1'b1, "halt");
        end
        // Reset inside HALT: halted drops at once, then T1 with count cleared.
        step(1'b0, 4'h0, IDLE, 6'b000000, 1'b0, "halt_rst");
        ecnt = 8'h00;
        step(1'b1, 4'h0, IDLE ^ EP ^ LM, 6'b000001, 1'b0, "post_halt_T1");
        step(1'b1, 4'h0, IDLE ^ CP,      6'b000010, 1'b0, "post_halt_T2");
        step(1'b1, 4'h0, IDLE ^ CE ^ L1, 6'b000100, 1'b0, "post_halt_T3");
        step(1'b1, 4'h7, IDLE,           6'b001000, 1'b0, "post_halt_T4");
        step(1'b1, 4'h7, IDLE,           6'b010000, 1'b0, "post_halt_T5");
        step(1'b1, 4'h7, IDLE,           6'b100000, 1'b0, "post_halt_T6");
        ecnt = ecnt + 8'd1;

        // 255 more NOPs: 256 retired since reset, counter wraps to 00.
        for (int i = 0; i < 255; i++) begin
            instr(4'h7, 4'h7, IDLE, IDLE, IDLE, "wrap_nop");
        end

        // ADD interrupted by reset in T5.
        step(1'b1, 4'h1, IDLE ^ EP ^ LM, 6'b000001, 1'b0, "wrap_T1");
        step(1'b1, 4'h1, IDLE ^ CP,      6'b000010, 1'b0, "mid_T2");
        step(1'b1, 4'h1, IDLE ^ CE ^ L1, 6'b000100, 1'b0, "mid_T3");
        step(1'b1, 4'h1, IDLE ^ E1 ^ LM, 6'b001000, 1'b0, "mid_T4");
        step(1'b0, 4'h1, IDLE,           6'b010000, 1'b0, "mid_rst_T5");
        ecnt = 8'h00;
        step(1'b1, 4'h1, IDLE ^ EP ^ LM, 6'b000001, 1'b0, "mid_after_T1");
        step(1'b1, 4'h1, IDLE ^ CP,      6'b000010, 1'b0, "mid_after_T2");

        @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control/sequencer for the SAP datapath. Consumes the 4-bit opcode from the instruction register and drives the control word back to the fetch/execute blocks: program counter, MAR, RAM, IR, accumulator, B register, ALU and output register.
- Built as a 6-state ring counter (T1..T6) plus a HALT state.
- State updates on the falling clock edge, so the control word is stable before the rising edge at which the datapath registers sample.

Parameters:
- OP_LDA, 4'h0, opcode for load accumulator
- OP_ADD, 4'h1, opcode for add
- OP_SUB, 4'h2, opcode for subtract
- OP_OUT, 4'hE, opcode for output
- OP_HLT, 4'hF, opcode for halt
- CNT_WIDTH, 8, width of the retired-instruction counter

Ports:
- clk  input  1  system clock; state register updates on negedge
- rst  input  1  synchronous reset, active-low, sampled on negedge clk
- opcode  input  4  IR upper nibble (ir_out)
- cp  output  1  PC increment, active-high
- ep  output  1  PC drive bus, active-high
- lm_n  output  1  MAR load, active-low
- ce_n  output  1  RAM drive bus, active-low
- l1_n  output  1  IR load, active-low
- e1_n  output  1  IR operand drive bus, active-low
- la_n  output  1  accumulator load, active-low
- ea  output  1  accumulator drive bus, active-high
- su  output  1  ALU subtract select, active-high
- eu  output  1  ALU drive bus, active-high
- lb_n  output  1  B register load, active-low
- lo_n  output  1  output register load, active-low
- t_state  output  6  one-hot ring position; bit0=T1 ... bit5=T6; 0 in HALT
- halted  output  1  high in HALT state
- instr_count  output  CNT_WIDTH  retired instructions

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. rst low at a negedge puts the state in T1 and clears instr_count.
- While rst is low, all control outputs are forced inactive combinationally: active-high outputs 0, active-low outputs 1, halted 0. This applies to reset mid-instruction and in HALT; the in-flight instruction is abandoned.
- "Inactive" below means every control output at its inactive level.
- Control outputs are Moore-decoded from state, and from opcode only in T4..T6. Only the signals listed in a state are active; all others are inactive.
- T1 (address): ep=1, lm_n=0.
- T2 (increment): cp=1.
- T3 (memory): ce_n=0, l1_n=0.
- T4:
  - LDA/ADD/SUB: e1_n=0, lm_n=0.
  - OUT: ea=1, lo_n=0.
  - HLT: inactive; next state HALT.
  - any other opcode: inactive (NOP).
- T5:
  - LDA: ce_n=0, la_n=0.
  - ADD/SUB: ce_n=0, lb_n=0.
  - others: inactive.
- T6:
  - ADD: eu=1, la_n=0.
  - SUB: eu=1, su=1, la_n=0.
  - others: inactive.
- Transitions: T1->T2->...->T6->T1 on successive negedges; T4 goes to HALT instead when opcode==OP_HLT.
- HALT is absorbing: all outputs inactive, halted=1, t_state=0. Only reset exits.
- opcode is sampled only through the T4..T6 decode; changes during T1..T3 have no effect.
- instr_count increments by 1 at the T6->T1 transition. It wraps modulo 2^CNT_WIDTH (8'hFF -> 8'h00). HLT does not count.
- Exactly one t_state bit is set in every non-HALT state. An illegal state encoding recovers to T1 at the next negedge.

Test Plan:
- Reset: hold rst=0 for 2 negedges with opcode=4'h1 -> all outputs inactive, instr_count=0. Release rst -> t_state=6'b000001, ep=1, lm_n=0.
- Fetch+LDA: opcode=4'h0, run 6 negedges from T1 -> observed sequence T1{ep,lm_n=0}, T2{cp}, T3{ce_n=0,l1_n=0}, T4{e1_n=0,lm_n=0}, T5{ce_n=0,la_n=0}, T6{none}. instr_count 0->1 on return to T1.
- SUB vs ADD: opcode=4'h2 -> T5 lb_n=0,ce_n=0; T6 eu=1,su=1,la_n=0. Repeat with 4'h1 -> T6 su=0.
- OUT and NOP: opcode=4'hE -> T4 ea=1,lo_n=0, T5/T6 inactive. Opcode=4'h7 -> T4..T6 inactive, instr_count still increments.
- HLT: opcode=4'hF -> after T4, halted=1, t_state=0, outputs inactive for 10+ negedges, instr_count frozen. rst=0 for one negedge -> T1, halted=0.
- Wrap + mid-op reset: run 256 NOP instructions -> instr_count returns to 8'h00. Assert rst during T5 of an ADD -> lb_n=1 immediately, next state T1.
